self_attention_head_scatter_split: RTL and testbench
====================================================

SELF_ATTENTION_HEAD_SCATTER_SPLIT -- requirements
Module: self_attention_head_scatter_split

Interface
REQ-001 The module SHALL have parameter NUM_HEADS, default 4: number of heads the input stream is scattered across.
REQ-002 The module SHALL have parameter GROUP_SIZE, default 2: number of consumers each head's handshake is forked to.
REQ-003 The module SHALL have parameter IN_DATA_TENSOR_SIZE_DIM_0, default 64: tensor width (columns).
REQ-004 The module SHALL have parameter IN_DATA_TENSOR_SIZE_DIM_1, default 32: tensor height (rows).
REQ-005 The module SHALL have parameter IN_DATA_PARALLELISM_DIM_0, default 4: columns per packet.
REQ-006 The module SHALL have parameter IN_DATA_PARALLELISM_DIM_1, default 4: rows per packet.
REQ-007 The module SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-008 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 The module SHALL have port in_valid, input, 1 bit: upstream packet valid.
REQ-010 The module SHALL have port in_ready, output, 1 bit: upstream packet accepted when in_valid && in_ready.
REQ-011 The module SHALL have port out_valid, output, NUM_HEADS*GROUP_SIZE bits: bit h*GROUP_SIZE+g is valid for head h, consumer g.
REQ-012 The module SHALL have port out_ready, input, NUM_HEADS*GROUP_SIZE bits: same indexing as out_valid.

Function
REQ-013 Derived constants SHALL be: HEAD_DIM0 = DIM_0/NUM_HEADS; HD = HEAD_DIM0/PAR_0 (packets per head per row); ROWS = DIM_1/PAR_1.
REQ-014 Elaboration SHALL fail when any of these divisions is inexact or when any parameter is 0.
REQ-015 The input stream SHALL be dim0-innermost: per packet-row, head 0 receives HD packets, then head 1 receives HD packets, ..., then head NUM_HEADS-1, then the next row begins.
REQ-016 Scatter state SHALL be block counter (0..HD-1), head counter (0..NUM_HEADS-1) and row counter (0..ROWS-1), each at least 1 bit wide.
REQ-017 Head valid SHALL be head_valid[h] = in_valid && (head counter == h), purely combinational.
REQ-018 in_ready SHALL equal head_ready[head counter], purely combinational, with no bubble cycle.
REQ-019 Counters SHALL advance only on an input handshake, in this order: block increments; at HD-1 block wraps to 0 and head increments; at head NUM_HEADS-1 head wraps to 0 and row increments; at row ROWS-1 all three wrap to 0, the next tensor starts and no idle cycle is inserted.
REQ-020 Each head SHALL feed a stateful fork with one done[g] flag per consumer: out_valid[h*GS+g] = head_valid[h] && !done[g].
REQ-021 The fork SHALL drive head_ready[h] = AND over g of (out_ready[h*GS+g] || done[g]).
REQ-022 On the cycle head_valid[h] && head_ready[h], the fork SHALL clear all done flags of head h.
REQ-023 Otherwise, the fork SHALL set done[g] for each consumer with out_valid && out_ready in that cycle.
REQ-024 Each consumer SHALL see exactly one handshake per packet regardless of the order in which consumers become ready.
REQ-025 Consumers stalled on a packet SHALL keep that packet's valid asserted until they complete their handshake.
REQ-026 With GROUP_SIZE=1, the fork SHALL degenerate to a wire (out_valid=head_valid, head_ready=out_ready) and SHALL hold no state.
REQ-027 When in_valid deasserts with consumers partially done, the done flags SHALL be held and the same packet SHALL be completed after in_valid reasserts; upstream must keep data stable.
REQ-028 Latency from input to out_valid SHALL be 0 cycles; throughput SHALL be 1 packet/cycle when all targeted consumers are ready.

Reset
REQ-029 While rst=1, all counters and all done flags SHALL clear to 0.
REQ-030 On the cycle after reset, routing SHALL target head 0, block 0, row 0; out_valid SHALL equal in_valid on head 0's consumers only, so it is 0 when in_valid=0.
REQ-031 Reset mid-tensor SHALL discard partial progress; the next accepted packet SHALL go to head 0.

Verification
REQ-032 NUM_HEADS=2, GS=2, DIM0=16, DIM1=4, PAR0=4, PAR1=2, all ready, in_valid held 8 cycles -> heads sequence 0,0,1,1,0,0,1,1; out_valid = 0011,0011,1100,1100,0011,0011,1100,1100; the 9th packet goes to head 0.
REQ-033 Same config, out_ready[1]=0 for 3 cycles on packet 0 -> out_valid[0] pulses once, out_valid[1] held for 3 cycles, in_ready=0 until bit 1 handshakes, then packet 1 goes to head 0.
REQ-034 Consumers ready on alternate cycles (g0 at t, g1 at t+1) -> in_ready asserts at t+1 only, one handshake each, no duplicate.
REQ-035 in_valid toggles 1/0 each cycle -> counters advance only on valid cycles; head sequence is identical to REQ-032.
REQ-036 Assert rst after 3 accepted packets -> the next accepted packet targets head 0 and all done flags are 0.
REQ-037 GS=1, NUM_HEADS=4, HD=1 -> out_valid rotates 0001,0010,0100,1000; in_ready = out_ready of the selected bit.

Source files
------------

// File: rtl/self_attention_head_scatter_split.sv
// Scatters a dim0-innermost packet stream across attention heads,
// forking each head's handshake to GROUP_SIZE consumers.
module self_attention_head_scatter_split #(
  parameter int NUM_HEADS                 = 4,
  parameter int GROUP_SIZE                = 2,
  parameter int IN_DATA_TENSOR_SIZE_DIM_0 = 64,
  parameter int IN_DATA_TENSOR_SIZE_DIM_1 = 32,
  parameter int IN_DATA_PARALLELISM_DIM_0 = 4,
  parameter int IN_DATA_PARALLELISM_DIM_1 = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_HEADS*GROUP_SIZE-1:0] out_valid,
  input  logic [NUM_HEADS*GROUP_SIZE-1:0] out_ready
);

  localparam int NH = NUM_HEADS;
  localparam int GS = GROUP_SIZE;
  localparam int D0 = IN_DATA_TENSOR_SIZE_DIM_0;
  localparam int D1 = IN_DATA_TENSOR_SIZE_DIM_1;
  localparam int P0 = IN_DATA_PARALLELISM_DIM_0;
  localparam int P1 = IN_DATA_PARALLELISM_DIM_1;

  // Safe divisors keep elaboration alive long enough to report the error
  localparam int NH_S = (NH > 0) ? NH : 1;
  localparam int P0_S = (P0 > 0) ? P0 : 1;
  localparam int P1_S = (P1 > 0) ? P1 : 1;

  localparam int HEAD_DIM0 = D0 / NH_S;
  localparam int HD        = HEAD_DIM0 / P0_S;
  localparam int ROWS      = D1 / P1_S;

  localparam bit BAD_PARAM =
    (NH == 0) || (GS == 0) || (D0 == 0) || (D1 == 0) ||
    (P0 == 0) || (P1 == 0) ||
    (D0 % NH_S != 0) || (HEAD_DIM0 % P0_S != 0) ||
    (D1 % P1_S != 0);

  if (BAD_PARAM) begin : g_bad_param
    $error("self_attention_head_scatter_split: bad parameters");
  end

  localparam int BW = (HD > 1)   ? $clog2(HD)   : 1;
  localparam int HW = (NH > 1)   ? $clog2(NH)   : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [BW-1:0] blk;
  logic [HW-1:0] head;
  logic [RW-1:0] row;

  logic [NH-1:0] head_valid;
  logic [NH-1:0] head_ready;

  logic last_blk;
  logic last_head;
  logic last_row;
  logic fire;

  assign last_blk  = (blk  == BW'(HD - 1));
  assign last_head = (head == HW'(NH - 1));
  assign last_row  = (row  == RW'(ROWS - 1));
  assign fire      = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    for (int h = 0; h < NH; h++) begin
      if (head == HW'(h)) in_ready = head_ready[h];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk  <= '0;
      head <= '0;
      row  <= '0;
    end else if (fire) begin
      if (!last_blk) begin
        blk <= blk + 1'b1;
      end else begin
        blk <= '0;
        if (!last_head) begin
          head <= head + 1'b1;
        end else begin
          head <= '0;
          row  <= last_row ? '0 : row + 1'b1;
        end
      end
    end
  end

  for (genvar h = 0; h < NH; h++) begin : g_head
    assign head_valid[h] = in_valid && (head == HW'(h));

    if (GS == 1) begin : g_wire
      assign out_valid[h]  = head_valid[h];
      assign head_ready[h] = out_ready[h];
    end else begin : g_fork
      logic [GS-1:0] done;
      logic [GS-1:0] ov;
      logic [GS-1:0] ordy;

      assign ordy = out_ready[h*GS +: GS];
      assign ov   = {GS{head_valid[h]}} & ~done;

      assign out_valid[h*GS +: GS] = ov;
      assign head_ready[h]         = &(ordy | done);

      // done remembers consumers already served for the pending packet
      always_ff @(posedge clk) begin
        if (rst) begin
          done <= '0;
        end else if (head_valid[h] && head_ready[h]) begin
          done <= '0;
        end else begin
          done <= done | (ov & ordy);
        end
      end
    end
  end

endmodule

// File: tb/tb_self_attention_head_scatter_split.sv
// Bench for self_attention_head_scatter_split: forked 2-head config
// plus a plain 4-head scatter.
module tb_self_attention_head_scatter_split;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv;
  logic       ir;
  logic [3:0] ov;
  logic [3:0] ordy;
  logic       iv2;
  logic       ir2;
  logic [3:0] ov2;
  logic [3:0] ordy2;

  int n_chk  = 0;
  int n_fail = 0;

  // reference: packets accepted since reset, consumers served so far
  int         pkt;
  logic [1:0] taken;
  int         pkt2;

  always #5 clk = ~clk;

  self_attention_head_scatter_split #(
    .NUM_HEADS(2), .GROUP_SIZE(2),
    .IN_DATA_TENSOR_SIZE_DIM_0(16), .IN_DATA_TENSOR_SIZE_DIM_1(4),
    .IN_DATA_PARALLELISM_DIM_0(4), .IN_DATA_PARALLELISM_DIM_1(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
    .out_valid(ov), .out_ready(ordy)
  );

  self_attention_head_scatter_split #(
    .NUM_HEADS(4), .GROUP_SIZE(1),
    .IN_DATA_TENSOR_SIZE_DIM_0(16), .IN_DATA_TENSOR_SIZE_DIM_1(4),
    .IN_DATA_PARALLELISM_DIM_0(4), .IN_DATA_PARALLELISM_DIM_1(2)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
    .out_valid(ov2), .out_ready(ordy2)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iv = 1'b0; iv2 = 1'b0;
    ordy = 4'hF; ordy2 = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    pkt = 0; taken = 2'b00; pkt2 = 0;
  endtask

  // drive one cycle on the forked instance and check against the model
  task automatic step(string tag, logic v, logic [3:0] r);
    int         h;
    logic [3:0] e_ov;
    logic       e_ir;
    @(negedge clk);
    iv = v; ordy = r;
    #1;
    h    = (pkt / 2) % 2;
    e_ov = 4'b0000;
    e_ir = 1'b1;
    for (int g = 0; g < 2; g++) begin
      if (v && !taken[g]) e_ov[h*2+g] = 1'b1;
      if (!(r[h*2+g] || taken[g])) e_ir = 1'b0;
    end
    chk({tag, "_ov"}, 32'(ov), 32'(e_ov));
    chk({tag, "_ir"}, 32'(ir), 32'(e_ir));
    if (v && e_ir) begin
      pkt++;
      taken = 2'b00;
    end else begin
      for (int g = 0; g < 2; g++)
        if (e_ov[h*2+g] && r[h*2+g]) taken[g] = 1'b1;
    end
  endtask

  initial begin
    logic [3:0] pat [8];
    logic [3:0] r;
    pat = '{4'h3, 4'h3, 4'hC, 4'hC, 4'h3, 4'h3, 4'hC, 4'hC};
    rst = 1'b1; iv = 1'b0; iv2 = 1'b0;
    ordy = 4'hF; ordy2 = 4'hF;
    pkt = 0; taken = 2'b00; pkt2 = 0;

    do_reset();
    step("rst", 1'b0, 4'hF);
    chk("rst_ov", 32'(ov), 32'h0);
    chk("rst_ir", 32'(ir), 32'h1);
    chk("rst_ov2", 32'(ov2), 32'h0);

    // back-to-back stream, all consumers ready
    for (int i = 0; i < 8; i++) begin
      step("seq", 1'b1, 4'hF);
      chk("seq_pat", 32'(ov), 32'(pat[i]));
    end
    step("ninth", 1'b1, 4'hF);
    chk("ninth_ov", 32'(ov), 32'h3);

    // consumer 1 stalls on packet 0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b1, 4'b1101);
      chk("stall_ov", 32'(ov), (i == 0) ? 32'h3 : 32'h2);
      chk("stall_ir", 32'(ir), 32'h0);
    end
    step("stall_rel", 1'b1, 4'hF);
    chk("stall_rel_ov", 32'(ov), 32'h2);
    chk("stall_rel_ir", 32'(ir), 32'h1);
    step("next_pkt", 1'b1, 4'hF);
    chk("next_pkt_ov", 32'(ov), 32'h3);

    // head 1 consumers ready on alternate cycles
    step("alt0", 1'b1, 4'b0100);
    chk("alt0_ir", 32'(ir), 32'h0);
    step("alt1", 1'b1, 4'b1000);
    chk("alt1_ov", 32'(ov), 32'h8);
    chk("alt1_ir", 32'(ir), 32'h1);
    step("alt2", 1'b1, 4'b0000);
    chk("alt2_ov", 32'(ov), 32'hC);

    // in_valid toggling
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step("tog", (i % 2) == 0, 4'hF);
      chk("tog_pat", 32'(ov), (i % 2 == 0) ? 32'(pat[i/2]) : 32'h0);
    end

    // reset mid-tensor with a partially served packet
    do_reset();
    for (int i = 0; i < 3; i++) step("pre", 1'b1, 4'hF);
    step("partial", 1'b1, 4'b0100);
    do_reset();
    step("post_rst", 1'b1, 4'b0000);
    chk("post_rst_ov", 32'(ov), 32'h3);
    chk("post_rst_ir", 32'(ir), 32'h0);
    step("post_rst2", 1'b1, 4'hF);

    // random traffic, held valid drops included
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      step("rnd", $urandom_range(0, 3) != 0, r);
    end

    // plain 4-head scatter
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv2 = 1'b1; ordy2 = 4'hF;
      #1;
      chk("rot_ov", 32'(ov2), 32'(1) << (pkt2 % 4));
      chk("rot_ir", 32'(ir2), 32'h1);
      pkt2++;
    end
    for (int i = 0; i < 24; i++) begin
      r = 4'($urandom);
      @(negedge clk);
      ordy2 = r;
      #1;
      chk("sel_ov", 32'(ov2), 32'(1) << (pkt2 % 4));
      chk("sel_ir", 32'(ir2), 32'(r[pkt2 % 4]));
      if (r[pkt2 % 4]) pkt2++;
    end
    @(negedge clk);
    iv2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
